// File: rtl/trdb_d5m_sensor_emulator.sv
`default_nettype none
// ============================================================================
// Module      : trdb_d5m_sensor_emulator
// Description : Stand-in for the TRDB_D5M camera daughter board. Generates
//               FVAL/LVAL framing and PIXEL_WIDTH-bit pixel data with a
//               programmable active area, blanking and four test patterns,
//               so the D5M driver and downstream image chain run without
//               the board fitted.
// Ports       : ul1Clock        - system clock
//               ul1Reset        - synchronous reset, active-high
//               ul1PixelEnable  - pixel-slot strobe (PIXCLK emulation)
//               ul1Enable       - run request, sampled at frame boundaries
//               ul2Pattern      - test pattern select, latched at frame start
//               ul1FrameValid   - FVAL
//               ul1LineValid    - LVAL
//               ulPixData       - pixel data, 0 while LVAL is low
//               ul16FrameCount  - completed frames, wraps 0xFFFF -> 0
//               ul1Busy         - high whenever the FSM is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module trdb_d5m_sensor_emulator #(
    parameter int PIXEL_WIDTH   = 12,
    parameter int ACTIVE_COLS   = 640,
    parameter int ACTIVE_ROWS   = 480,
    parameter int H_BLANK       = 16,
    parameter int V_BLANK_LINES = 4,
    parameter int FV_GUARD      = 2
) (
    input  logic                   ul1Clock,
    input  logic                   ul1Reset,
    input  logic                   ul1PixelEnable,
    input  logic                   ul1Enable,
    input  logic [1:0]             ul2Pattern,
    output logic                   ul1FrameValid,
    output logic                   ul1LineValid,
    output logic [PIXEL_WIDTH-1:0] ulPixData,
    output logic [15:0]            ul16FrameCount,
    output logic                   ul1Busy
);

    localparam int c_VB_SLOTS = V_BLANK_LINES * (ACTIVE_COLS + H_BLANK);
    localparam int c_CNT_MAX0 = (FV_GUARD > H_BLANK) ? FV_GUARD : H_BLANK;
    localparam int c_CNT_MAX  = (c_CNT_MAX0 > c_VB_SLOTS) ? c_CNT_MAX0 : c_VB_SLOTS;
    localparam int c_COL_W    = (ACTIVE_COLS > 1) ? $clog2(ACTIVE_COLS) : 1;
    localparam int c_ROW_W    = (ACTIVE_ROWS > 1) ? $clog2(ACTIVE_ROWS) : 1;
    localparam int c_CNT_W    = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

    localparam logic [c_COL_W-1:0] c_COL_LAST   = c_COL_W'(ACTIVE_COLS - 1);
    localparam logic [c_COL_W-1:0] c_COL_ONE    = c_COL_W'(1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST   = c_ROW_W'(ACTIVE_ROWS - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_ONE    = c_ROW_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_GUARD_LAST = c_CNT_W'(FV_GUARD - 1);
    localparam logic [c_CNT_W-1:0] c_HB_LAST    = c_CNT_W'(H_BLANK - 1);
    localparam logic [c_CNT_W-1:0] c_VB_LAST    =
        c_CNT_W'(((c_VB_SLOTS > 0) ? c_VB_SLOTS : 1) - 1);

    // Bayer values are defined for 12 bits; the top PIXEL_WIDTH bits of
    // {value, zeros} give the left-aligned value for any width.
    localparam logic [PIXEL_WIDTH+11:0] c_G1_EXT = {12'hFFF, {PIXEL_WIDTH{1'b0}}};
    localparam logic [PIXEL_WIDTH+11:0] c_R_EXT  = {12'h800, {PIXEL_WIDTH{1'b0}}};
    localparam logic [PIXEL_WIDTH+11:0] c_B_EXT  = {12'h400, {PIXEL_WIDTH{1'b0}}};
    localparam logic [PIXEL_WIDTH+11:0] c_G2_EXT = {12'h0FF, {PIXEL_WIDTH{1'b0}}};
    localparam logic [PIXEL_WIDTH-1:0]  c_G1 = c_G1_EXT[PIXEL_WIDTH+11 -: PIXEL_WIDTH];
    localparam logic [PIXEL_WIDTH-1:0]  c_R  = c_R_EXT[PIXEL_WIDTH+11 -: PIXEL_WIDTH];
    localparam logic [PIXEL_WIDTH-1:0]  c_B  = c_B_EXT[PIXEL_WIDTH+11 -: PIXEL_WIDTH];
    localparam logic [PIXEL_WIDTH-1:0]  c_G2 = c_G2_EXT[PIXEL_WIDTH+11 -: PIXEL_WIDTH];

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_LEAD   = 3'd1;
    localparam logic [2:0] c_ST_ACTIVE = 3'd2;
    localparam logic [2:0] c_ST_HBLANK = 3'd3;
    localparam logic [2:0] c_ST_TAIL   = 3'd4;
    localparam logic [2:0] c_ST_VBLANK = 3'd5;

    logic [2:0]             r_state;
    logic [c_COL_W-1:0]     r_col;
    logic [c_ROW_W-1:0]     r_row;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [1:0]             r_pattern;
    logic [15:0]            r_frame_count;
    logic                   r_fval;
    logic                   r_lval;
    logic [PIXEL_WIDTH-1:0] r_data;
    logic                   r_busy;

    logic [c_COL_W-1:0]     w_pix_col;
    logic [c_ROW_W-1:0]     w_pix_row;
    logic [PIXEL_WIDTH-1:0] w_pix;
    logic                   w_frame_end;
    logic                   w_start;

    // Coordinates of the pixel that the next slot will carry. Outputs are
    // registered, so the value is prepared one slot ahead.
    always_comb begin
        w_pix_col = '0;
        w_pix_row = r_row;
        if (r_state == c_ST_ACTIVE) begin
            w_pix_col = r_col + c_COL_ONE;
        end
        if (r_state == c_ST_HBLANK) begin
            w_pix_row = r_row + c_ROW_ONE;
        end
    end

    always_comb begin
        w_pix = '0;
        case (r_pattern)
            2'd0: w_pix = PIXEL_WIDTH'(w_pix_col);
            2'd1: w_pix = PIXEL_WIDTH'(32'(w_pix_col) + 32'(w_pix_row));
            2'd2: begin
                case ({w_pix_row[0], w_pix_col[0]})
                    2'b00:   w_pix = c_G1;
                    2'b01:   w_pix = c_R;
                    2'b10:   w_pix = c_B;
                    default: w_pix = c_G2;
                endcase
            end
            default: w_pix = PIXEL_WIDTH'(r_frame_count);
        endcase
    end

    // End of a frame period: last VBLANK slot, or the last TAIL slot when
    // vertical blanking is configured away.
    assign w_frame_end = ((r_state == c_ST_VBLANK) && (r_cnt == c_VB_LAST)) ||
                         ((c_VB_SLOTS == 0) && (r_state == c_ST_TAIL) &&
                          (r_cnt == c_GUARD_LAST));
    assign w_start     = ul1Enable && ((r_state == c_ST_IDLE) || w_frame_end);

    always_ff @(posedge ul1Clock) begin
        if (ul1Reset) begin
            r_state       <= c_ST_IDLE;
            r_col         <= '0;
            r_row         <= '0;
            r_cnt         <= '0;
            r_pattern     <= 2'd0;
            r_frame_count <= 16'd0;
            r_fval        <= 1'b0;
            r_lval        <= 1'b0;
            r_data        <= '0;
            r_busy        <= 1'b0;
        end else if (ul1PixelEnable) begin
            case (r_state)
                c_ST_IDLE: ;
                c_ST_LEAD: begin
                    if (r_cnt == c_GUARD_LAST) begin
                        r_state <= c_ST_ACTIVE;
                        r_cnt   <= '0;
                        r_lval  <= 1'b1;
                        r_data  <= w_pix;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_ST_ACTIVE: begin
                    if (r_col == c_COL_LAST) begin
                        r_cnt   <= '0;
                        r_lval  <= 1'b0;
                        r_data  <= '0;
                        r_state <= (r_row == c_ROW_LAST) ? c_ST_TAIL : c_ST_HBLANK;
                    end else begin
                        r_col  <= w_pix_col;
                        r_data <= w_pix;
                    end
                end
                c_ST_HBLANK: begin
                    if (r_cnt == c_HB_LAST) begin
                        r_state <= c_ST_ACTIVE;
                        r_cnt   <= '0;
                        r_col   <= '0;
                        r_row   <= w_pix_row;
                        r_lval  <= 1'b1;
                        r_data  <= w_pix;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_ST_TAIL: begin
                    if (r_cnt == c_GUARD_LAST) begin
                        r_frame_count <= r_frame_count + 16'd1;
                        r_cnt         <= '0;
                        r_state       <= c_ST_VBLANK;
                        r_fval        <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_ST_VBLANK: begin
                    if (r_cnt != c_VB_LAST) begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase

            // Frame-boundary decisions override the per-state updates above.
            if (w_start) begin
                r_state   <= c_ST_LEAD;
                r_pattern <= ul2Pattern;
                r_col     <= '0;
                r_row     <= '0;
                r_cnt     <= '0;
                r_fval    <= 1'b1;
                r_lval    <= 1'b0;
                r_data    <= '0;
                r_busy    <= 1'b1;
            end else if (w_frame_end) begin
                r_state <= c_ST_IDLE;
                r_cnt   <= '0;
                r_fval  <= 1'b0;
                r_lval  <= 1'b0;
                r_data  <= '0;
                r_busy  <= 1'b0;
            end
        end
    end

    assign ul1FrameValid  = r_fval;
    assign ul1LineValid   = r_lval;
    assign ulPixData      = r_data;
    assign ul16FrameCount = r_frame_count;
    assign ul1Busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_trdb_d5m_sensor_emulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_trdb_d5m_sensor_emulator
// Description : Self-checking bench for trdb_d5m_sensor_emulator. Expected
//               framing and pixel values come from a slot-index model of the
//               frame period.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trdb_d5m_sensor_emulator;

    localparam int W   = 12;
    localparam int C   = 4;
    localparam int R   = 2;
    localparam int H   = 2;
    localparam int VBL = 1;
    localparam int G   = 1;
    localparam int ACT_LEN = R * C + (R - 1) * H;
    localparam int VB_LEN  = VBL * (C + H);
    localparam int PERIOD  = 2 * G + ACT_LEN + VB_LEN;

    logic         clk = 1'b0;
    logic         rst;
    logic         pix_en;
    logic         run_en;
    logic [1:0]   pattern;
    logic         fval;
    logic         lval;
    logic [W-1:0] data;
    logic [15:0]  fcount;
    logic         busy;

    int checks  = 0;
    int errors  = 0;
    int lv_viol = 0;
    int m_count = 0;

    trdb_d5m_sensor_emulator #(
        .PIXEL_WIDTH  (W),
        .ACTIVE_COLS  (C),
        .ACTIVE_ROWS  (R),
        .H_BLANK      (H),
        .V_BLANK_LINES(VBL),
        .FV_GUARD     (G)
    ) dut (
        .ul1Clock      (clk),
        .ul1Reset      (rst),
        .ul1PixelEnable(pix_en),
        .ul1Enable     (run_en),
        .ul2Pattern    (pattern),
        .ul1FrameValid (fval),
        .ul1LineValid  (lval),
        .ulPixData     (data),
        .ul16FrameCount(fcount),
        .ul1Busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (lval && !fval) lv_viol++;
    end

    function automatic logic [W-1:0] model_pix(input int pat, input int col,
                                               input int row, input int cnt);
        case (pat)
            0: return W'(col);
            1: return W'(col + row);
            2: begin
                if (row % 2 == 0) return (col % 2 == 0) ? 12'hFFF : 12'h800;
                else              return (col % 2 == 0) ? 12'h400 : 12'h0FF;
            end
            default: return W'(cnt);
        endcase
    endfunction

    // Slot s counts from the first LEAD slot of the frame period.
    task automatic model_slot(input int s, input int pat, input int cnt,
                              output logic efv, output logic elv,
                              output logic [W-1:0] ed);
        int o;
        int line;
        int p;
        efv = 1'b0;
        elv = 1'b0;
        ed  = '0;
        if (s < G) begin
            efv = 1'b1;
        end else if (s < G + ACT_LEN) begin
            efv  = 1'b1;
            o    = s - G;
            line = o / (C + H);
            p    = o % (C + H);
            if (p < C) begin
                elv = 1'b1;
                ed  = model_pix(pat, p, line, cnt);
            end
        end else if (s < 2 * G + ACT_LEN) begin
            efv = 1'b1;
        end
    endtask

    // Idle (strobe-low) cycles first, each checked for held outputs, then one
    // enabled slot.
    task automatic advance(input int gap);
        logic [30:0] snap;
        snap = {fval, lval, data, fcount, busy};
        for (int i = 0; i < gap; i++) begin
            pix_en = 1'b0;
            @(posedge clk);
            #1;
            checks++;
            if ({fval, lval, data, fcount, busy} !== snap) begin
                errors++;
                $display("FAIL hold: got %h expected %h", {fval, lval, data, fcount, busy}, snap);
            end
        end
        pix_en = 1'b1;
        @(posedge clk);
        #1;
        pix_en = 1'b0;
    endtask

    // Entry: DUT shows the first LEAD slot of a frame latched with pat.
    // next_pat/next_en are driven from inside row 0.
    task automatic run_frame(input int pat, input logic [1:0] next_pat,
                             input logic next_en, input int gap_mode);
        int base;
        logic efv, elv;
        logic [W-1:0] ed;
        logic [15:0] ecnt;
        base = m_count;
        for (int s = 0; s < PERIOD; s++) begin
            model_slot(s, pat, base, efv, elv, ed);
            ecnt = (s >= 2 * G + ACT_LEN) ? 16'(base + 1) : 16'(base);
            checks++;
            if ({fval, lval, data} !== {efv, elv, ed}) begin
                errors++;
                $display("FAIL slot pat=%0d s=%0d: got fv=%b lv=%b d=%h expected fv=%b lv=%b d=%h",
                         pat, s, fval, lval, data, efv, elv, ed);
            end
            checks++;
            if (fcount !== ecnt || busy !== 1'b1) begin
                errors++;
                $display("FAIL count/busy s=%0d: got cnt=%h busy=%b expected cnt=%h busy=1",
                         s, fcount, busy, ecnt);
            end
            if (s == G + 1) begin
                run_en  = next_en;
                pattern = next_pat;
            end
            advance((gap_mode < 0) ? int'($urandom_range(0, 3)) : gap_mode);
        end
        m_count = (base + 1) & 16'hFFFF;
    endtask

    task automatic check_idle(input string tag);
        checks++;
        if ({fval, lval, data, busy} !== '0 || fcount !== 16'(m_count)) begin
            errors++;
            $display("FAIL %s: got fv=%b lv=%b d=%h busy=%b cnt=%h expected all 0, cnt=%h",
                     tag, fval, lval, data, busy, fcount, 16'(m_count));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; pix_en = 1'b1; run_en = 1'b1; pattern = 2'd1;
        repeat (3) @(posedge clk);
        #1;
        m_count = 0;
        check_idle("reset");
        rst = 1'b0; pix_en = 1'b0;
        @(posedge clk);
        #1;
        check_idle("reset_hold_no_strobe");
    endtask

    task automatic test_basic();
        pattern = 2'd0;
        run_en  = 1'b1;
        advance(0);
        run_frame(0, 2'd0, 1'b1, 0);
        run_frame(0, 2'd2, 1'b1, 0);
    endtask

    task automatic test_bayer();
        run_frame(2, 2'd0, 1'b1, 0);
    endtask

    task automatic test_pixel_rate();
        run_frame(0, 2'd1, 1'b1, 2);
    endtask

    task automatic test_random_frames();
        logic [1:0] cur;
        logic [1:0] nxt;
        cur = 2'd1;
        for (int f = 0; f < 3; f++) begin
            nxt = 2'($urandom_range(0, 2));
            run_frame(int'(cur), nxt, 1'b1, -1);
            cur = nxt;
        end
        run_frame(int'(cur), 2'd0, 1'b1, -1);
    endtask

    task automatic test_reset_mid();
        logic [1:0] p;
        p = 2'($urandom_range(0, 2));
        pattern = p;
        for (int i = 0; i < G + 2; i++) advance(0);
        checks++;
        if (lval !== 1'b1) begin
            errors++;
            $display("FAIL mid_active_entry: got lv=%b expected 1", lval);
        end
        rst = 1'b1; pix_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; pix_en = 1'b0;
        m_count = 0;
        check_idle("reset_mid_frame");
        advance(0);
        run_frame(int'(p), 2'd0, 1'b1, 0);
    endtask

    task automatic test_enable_drop();
        run_frame(0, 2'd1, 1'b0, 0);
        check_idle("enable_drop_idle");
        for (int i = 0; i < 3; i++) advance($urandom_range(0, 2));
        check_idle("enable_low_stays_idle");
    endtask

    task automatic test_wrap();
        force dut.r_frame_count = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.r_frame_count;
        @(posedge clk);
        #1;
        m_count = 16'hFFFE;
        check_idle("preload");
        pattern = 2'd3;
        run_en  = 1'b1;
        advance(0);
        run_frame(3, 2'd3, 1'b1, 0);
        run_frame(3, 2'd3, 1'b1, 0);
        run_frame(3, 2'd0, 1'b0, 0);
        check_idle("after_wrap");
        checks++;
        if (lv_viol != 0) begin
            errors++;
            $display("FAIL lval_without_fval: got %0d violations expected 0", lv_viol);
        end
    endtask

    initial begin
        rst = 1'b1; pix_en = 1'b0; run_en = 1'b0; pattern = 2'd0;
        test_reset();
        test_basic();
        test_bayer();
        test_pixel_rate();
        test_random_frames();
        test_reset_mid();
        test_enable_drop();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
